rsa_bus_ctrl: RTL

- Memory-mapped controller between the RV32I core's RSA port (rsa_en / ack_from_rsa stall handshake) and the modular-exponentiation accelerator.
- Decodes core load/store accesses into an operand/control/status register bank and launches the accelerator.
- Withholds ack while a RESULT read waits for completion, so the core's PC stalls.

---
 rtl/rsa_bus_pkg.sv | 33 +++
 rtl/rsa_operand_reg.sv | 28 ++
 rtl/rsa_bus_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rsa_bus_pkg.sv
// rtl/rsa_bus_pkg.sv - shared constants and FSM encoding for the RSA bus controller
// Purpose: register offsets (addr[4:2]), STATUS bit indices, controller state
//          encoding and the data word returned when a stalled RESULT read expires.
// Ports:   none (package).
// Config:  RSA_TIMEOUT_EN adds the ST_TIMEOUT state.
package rsa_bus_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_MSG    = 3'd2;
  localparam logic [2:0] OFF_EXP    = 3'd3;
  localparam logic [2:0] OFF_MOD    = 3'd4;
  localparam logic [2:0] OFF_RESULT = 3'd5;

  localparam int CTRL_START   = 0;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_TIMEOUT = 3;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESP      = 2'd1,
    ST_WAIT_DONE = 2'd2
`ifdef RSA_TIMEOUT_EN
    ,
    ST_TIMEOUT   = 2'd3
`endif
  } rsa_state_e;

endpackage

// File: rtl/rsa_operand_reg.sv
// rtl/rsa_operand_reg.sv - DW-bit operand register with byte-lane write enables
// Purpose: holds one accelerator operand; each byte lane loads independently.
// Ports:   clk  - system clock
//          clr  - synchronous clear (highest priority)
//          be   - per-byte write enables, bit i covers d[8i+7:8i]
//          d    - write data
//          q    - register contents
module rsa_operand_reg #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0]   d,
  output logic [DW-1:0]   q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else begin
      for (int i = 0; i < DW/8; i++) begin
        if (be[i]) q[i*8 +: 8] <= d[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/rsa_bus_ctrl.sv
// rtl/rsa_bus_ctrl.sv - core-to-accelerator register bank with stalling RESULT read
// Purpose: decodes core loads/stores (addr[4:2]) into CTRL/STATUS/MSG/EXP/MOD/RESULT,
//          launches the modular-exponentiation accelerator and holds ack low while
//          a RESULT read waits for completion.
// Ports:   clk, rst (sync, active-high)
//          rsa_en, addr, wdata, store_we (0000 = load) - core request, stable until ack
//          rdata, ack                                  - core response (ack is 1 cycle)
//          rsa_start, rsa_msg, rsa_exp, rsa_mod        - accelerator launch + operands
//          rsa_done, rsa_result                        - accelerator completion
// Config:  RSA_TIMEOUT_EN - bounds the RESULT stall to TIMEOUT_CYCLES and reports
//          expiry through STATUS bit3 and TIMEOUT_DATA.
module rsa_bus_ctrl
  import rsa_bus_pkg::*;
#(
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rsa_en,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    store_we,
  output logic [31:0]   rdata,
  output logic          ack,
  output logic          rsa_start,
  output logic [DW-1:0] rsa_msg,
  output logic [DW-1:0] rsa_exp,
  output logic [DW-1:0] rsa_mod,
  input  logic          rsa_done,
  input  logic [DW-1:0] rsa_result
);

  localparam int NB = DW / 8;

  rsa_state_e    state_q, state_d;
  logic          busy, done_flag, err;
  logic [DW-1:0] result_q;
  logic [31:0]   status_word, rd_mux;

  logic [2:0] reg_off;
  logic       is_write, accept, wr_acc, done_ok, busy_eff;
  logic       start_req, start_ok, result_stall, err_clr;
  logic       unused_addr_bits;

  assign reg_off          = addr[4:2];
  assign unused_addr_bits = ^{addr[31:5], addr[1:0]};
  assign is_write         = |store_we;
  // Only IDLE samples the request, so a request still held during RESP is not re-taken.
  assign accept           = (state_q == ST_IDLE) && rsa_en;
  assign wr_acc           = accept && is_write;
  assign done_ok          = rsa_done && busy;
  // A done arriving on the same edge retires the run before anything else looks at busy.
  assign busy_eff         = busy && !rsa_done;
  assign start_req        = wr_acc && (reg_off == OFF_CTRL) && store_we[0] && wdata[CTRL_START];
  assign start_ok         = start_req && !busy_eff;
  assign result_stall     = accept && !is_write && (reg_off == OFF_RESULT) && busy_eff;
  assign err_clr          = wr_acc && (reg_off == OFF_STATUS) && store_we[0] && wdata[STAT_ERR];

`ifdef RSA_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_flag;
  logic          tmo_hit;
  assign tmo_hit = (state_q == ST_WAIT_DONE) && !done_ok && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Operand bank: byte lanes gated by the decoded offset; cleared by reset.
  logic [NB-1:0] msg_be, exp_be, mod_be;
  assign msg_be = (wr_acc && reg_off == OFF_MSG) ? NB'(store_we) : '0;
  assign exp_be = (wr_acc && reg_off == OFF_EXP) ? NB'(store_we) : '0;
  assign mod_be = (wr_acc && reg_off == OFF_MOD) ? NB'(store_we) : '0;

  rsa_operand_reg #(.DW(DW)) u_msg (.clk(clk), .clr(rst), .be(msg_be), .d(DW'(wdata)), .q(rsa_msg));
  rsa_operand_reg #(.DW(DW)) u_exp (.clk(clk), .clr(rst), .be(exp_be), .d(DW'(wdata)), .q(rsa_exp));
  rsa_operand_reg #(.DW(DW)) u_mod (.clk(clk), .clr(rst), .be(mod_be), .d(DW'(wdata)), .q(rsa_mod));

  always_comb begin
    status_word            = '0;
    status_word[STAT_BUSY] = busy;
    status_word[STAT_DONE] = done_flag;
    status_word[STAT_ERR]  = err;
`ifdef RSA_TIMEOUT_EN
    status_word[STAT_TIMEOUT] = tmo_flag;
`endif
  end

  always_comb begin
    rd_mux = '0;
    case (reg_off)
      OFF_STATUS: rd_mux = status_word;
      OFF_MSG:    rd_mux = 32'(rsa_msg);
      OFF_EXP:    rd_mux = 32'(rsa_exp);
      OFF_MOD:    rd_mux = 32'(rsa_mod);
      OFF_RESULT: rd_mux = 32'(done_ok ? rsa_result : result_q);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rsa_en) state_d = result_stall ? ST_WAIT_DONE : ST_RESP;
      end
      ST_RESP: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (done_ok) state_d = ST_RESP;
`ifdef RSA_TIMEOUT_EN
        else if (tmo_hit) state_d = ST_TIMEOUT;
`endif
      end
`ifdef RSA_TIMEOUT_EN
      // Response cycle for an expired stall; rdata already holds TIMEOUT_DATA.
      ST_TIMEOUT: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata     <= '0;
      rsa_start <= 1'b0;
      busy      <= 1'b0;
      done_flag <= 1'b0;
      err       <= 1'b0;
      result_q  <= '0;
`ifdef RSA_TIMEOUT_EN
      tmo_cnt   <= '0;
      tmo_flag  <= 1'b0;
`endif
    end else begin
      rsa_start <= 1'b0;

      if (done_ok) begin
        result_q  <= rsa_result;
        busy      <= 1'b0;
        done_flag <= 1'b1;
      end

      // Ordered after the done update so a coincident done+start ends up busy again.
      if (start_ok) begin
        rsa_start <= 1'b1;
        busy      <= 1'b1;
        done_flag <= 1'b0;
`ifdef RSA_TIMEOUT_EN
        tmo_flag  <= 1'b0;
`endif
      end else if (start_req) begin
        err <= 1'b1;
      end

      if (err_clr) err <= 1'b0;

      if (accept) begin
        rdata <= is_write ? '0 : rd_mux;
      end else if (state_q == ST_WAIT_DONE && done_ok) begin
        rdata <= 32'(rsa_result);
      end

`ifdef RSA_TIMEOUT_EN
      if (state_q == ST_WAIT_DONE && !done_ok) begin
        if (tmo_hit) begin
          rdata    <= TIMEOUT_DATA;
          tmo_flag <= 1'b1;
          busy     <= 1'b0;
          tmo_cnt  <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
`endif
    end
  end

endmodule
